race_timer_ctrl: RTL

Race sequencing controller built around an internal 1 Hz tick prescaler. It runs the start countdown (N..1, then GO), times the race in whole seconds, supports pause/resume and abort, and flags time-out. It sits between the game input logic and the display/score logic, and is the single owner of the seconds time base for the race.

---
 rtl/race_timer_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/race_timer_ctrl.sv
// Race sequencing controller with an internal 1 s tick prescaler.
// Runs the start countdown (COUNTDOWN..1, then GO), times the race in whole
// seconds, supports pause/resume and abort, and flags time-out at MAX_SECONDS.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      level; starts a race from IDLE or DONE
//   pause      level; high holds the race (RACING/PAUSED only)
//   abort      pulse; returns to IDLE from any state
//   finish     pulse; player crossed the line (RACING only)
//   tick       one-cycle pulse per elapsed second
//   state      0=IDLE 1=COUNTDOWN 2=RACING 3=PAUSED 4=DONE
//   count_val  current countdown digit, 0 outside COUNTDOWN
//   go         high from countdown end until the first race second elapses
//   race_secs  elapsed race seconds, saturating at MAX_SECONDS
//   time_out   sticky flag: DONE was reached through the time limit
module race_timer_ctrl #(
  parameter int unsigned TICK_PERIOD = 50000000,
  parameter int unsigned COUNTDOWN   = 3,
  parameter int unsigned MAX_SECONDS = 999
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  input  logic       finish,
  output logic       tick,
  output logic [2:0] state,
  output logic [3:0] count_val,
  output logic       go,
  output logic [9:0] race_secs,
  output logic       time_out
);

  localparam int unsigned PW = (TICK_PERIOD > 2) ? $clog2(TICK_PERIOD) : 1;
  localparam logic [PW-1:0] PrescLast = PW'(TICK_PERIOD - 1);
  localparam logic [3:0]    CountInit = 4'(COUNTDOWN);
  localparam logic [9:0]    MaxSecs   = 10'(MAX_SECONDS);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StCountdown = 3'd1,
    StRacing    = 3'd2,
    StPaused    = 3'd3,
    StDone      = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic [3:0]    count_q, count_d;
  logic          go_q, go_d;
  logic [9:0]    secs_q, secs_d;
  logic          time_out_q, time_out_d;

  logic          wrap;
  logic [9:0]    secs_inc;

  assign wrap     = (presc_q == PrescLast);
  assign secs_inc = secs_q + 10'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      tick_q     <= 1'b0;
      count_q    <= '0;
      go_q       <= 1'b0;
      secs_q     <= '0;
      time_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      count_q    <= count_d;
      go_q       <= go_d;
      secs_q     <= secs_d;
      time_out_q <= time_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    tick_d     = 1'b0;
    count_d    = count_q;
    go_d       = go_q;
    secs_d     = secs_q;
    time_out_d = time_out_q;

    if (abort) begin
      state_d    = StIdle;
      presc_d    = '0;
      count_d    = '0;
      go_d       = 1'b0;
      secs_d     = '0;
      time_out_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          presc_d = '0;
          if (start) begin
            state_d    = StCountdown;
            count_d    = CountInit;
            go_d       = 1'b0;
            secs_d     = '0;
            time_out_d = 1'b0;
          end
        end

        // pause and finish have no effect during the countdown
        StCountdown: begin
          if (wrap) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (count_q == 4'd1) begin
              state_d = StRacing;
              count_d = '0;
              go_d    = 1'b1;
            end else begin
              count_d = count_q - 4'd1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end

        StRacing: begin
          if (finish) begin
            // A coincident wrap is dropped: the time stays frozen as-is.
            state_d = StDone;
            presc_d = '0;
          end else if (pause) begin
            // Prescaler holds so the partial second survives the pause.
            state_d = StPaused;
          end else if (wrap) begin
            presc_d = '0;
            tick_d  = 1'b1;
            go_d    = 1'b0;
            secs_d  = secs_inc;
            if (secs_inc >= MaxSecs) begin
              secs_d     = MaxSecs;
              state_d    = StDone;
              presc_d    = '0;
              time_out_d = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end

        StPaused: begin
          if (!pause) begin
            state_d = StRacing;
          end
        end

        default: begin
          state_d = StIdle;
          presc_d = '0;
        end
      endcase
    end
  end

  assign tick      = tick_q;
  assign state     = state_q;
  assign count_val = count_q;
  assign go        = go_q;
  assign race_secs = secs_q;
  assign time_out  = time_out_q;

endmodule
